// File: rtl/udp_port_router_pkg.sv
// udp_port_router_pkg: shared FSM states, header types and destination-port lookup
package udp_port_router_pkg;

    localparam int MAX_CHANNELS = 16;

    typedef logic [15:0] port_t;
    typedef logic [MAX_CHANNELS*16-1:0] port_list_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_LOOKUP,
        RX_HDR,
        RX_PAYLOAD,
        RX_DROP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HDR,
        TX_PAYLOAD
    } tx_state_t;

    typedef struct packed {
        logic [31:0] ip_source_ip;
        port_t       source_port;
        port_t       dest_port;
        logic [15:0] length;
        logic [15:0] checksum;
    } udp_rx_hdr_t;

    typedef struct packed {
        logic [31:0] ip_dest_ip;
        port_t       source_port;
        port_t       dest_port;
        logic [15:0] length;
        logic [15:0] checksum;
    } udp_tx_hdr_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] index;
    } lookup_t;

    // Scanning from the top down lets the lowest matching index overwrite the result last
    function automatic lookup_t port_lookup(input port_list_t port_list, input int channels,
                                            input port_t dest_port);
        lookup_t r;
        r = '0;
        for (int k = MAX_CHANNELS - 1; k >= 0; k--)
            if (k < channels && port_list[k*16 +: 16] == dest_port) begin
                r.hit   = 1'b1;
                r.index = 4'(k);
            end
        return r;
    endfunction

endpackage

// File: rtl/udp_port_router_rr_arbiter.sv
// rr_arbiter: round-robin arbiter; the registered pointer is the current/last grant
module rr_arbiter #(
    parameter int N = 3,
    localparam int W = N > 1 ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic         any,
    output logic [N-1:0] gnt_oh,
    output logic [W-1:0] gnt_bin
);

    logic [W-1:0] ptr_q, ptr_d, nxt, idx;

    // Search starts one past the last grant and takes the first requester
    always_comb begin
        nxt = ptr_q;
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(ptr_q) + i) % N);
            if (!any && req[idx]) begin
                any = 1'b1;
                nxt = idx;
            end
        end
        ptr_d = update && any ? nxt : ptr_q;
        gnt_oh = '0;
        gnt_oh[ptr_q] = 1'b1;
    end

    // Pointer resets to the last channel so channel 0 is searched first
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr_q <= W'(N - 1);
        else ptr_q <= ptr_d;

    assign gnt_bin = ptr_q;

endmodule

// File: rtl/udp_port_router.sv
// udp_port_router: RX demux by UDP destination port, TX round-robin mux with frame locking.
// Statistics counters exist only when UDP_PORT_ROUTER_STATS_EN is defined.
module udp_port_router
    import udp_port_router_pkg::*;
#(
    parameter int                     CHANNELS        = 3,
    parameter logic [CHANNELS*16-1:0] PORT_LIST       = {16'd9999, 16'd5678, 16'd1234},
    parameter int                     DEFAULT_CHANNEL = -1,
    parameter int                     STAT_WIDTH      = 32,
    localparam int                    GW              = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rx_hdr_valid,
    output logic                            rx_hdr_ready,
    input  udp_rx_hdr_t                     rx_hdr,
    input  logic [7:0]                      rx_tdata,
    input  logic                            rx_tvalid,
    output logic                            rx_tready,
    input  logic                            rx_tlast,
    input  logic                            rx_tuser,
    output logic [CHANNELS-1:0]             rx_ch_hdr_valid,
    input  logic [CHANNELS-1:0]             rx_ch_hdr_ready,
    output udp_rx_hdr_t [CHANNELS-1:0]      rx_ch_hdr,
    output logic [CHANNELS-1:0][7:0]        rx_ch_tdata,
    output logic [CHANNELS-1:0]             rx_ch_tvalid,
    input  logic [CHANNELS-1:0]             rx_ch_tready,
    output logic [CHANNELS-1:0]             rx_ch_tlast,
    output logic [CHANNELS-1:0]             rx_ch_tuser,
    input  logic [CHANNELS-1:0]             tx_ch_hdr_valid,
    output logic [CHANNELS-1:0]             tx_ch_hdr_ready,
    input  udp_tx_hdr_t [CHANNELS-1:0]      tx_ch_hdr,
    input  logic [CHANNELS-1:0][7:0]        tx_ch_tdata,
    input  logic [CHANNELS-1:0]             tx_ch_tvalid,
    output logic [CHANNELS-1:0]             tx_ch_tready,
    input  logic [CHANNELS-1:0]             tx_ch_tlast,
    input  logic [CHANNELS-1:0]             tx_ch_tuser,
    output logic                            tx_hdr_valid,
    input  logic                            tx_hdr_ready,
    output udp_tx_hdr_t                     tx_hdr,
    output logic [7:0]                      tx_tdata,
    output logic                            tx_tvalid,
    input  logic                            tx_tready,
    output logic                            tx_tlast,
    output logic                            tx_tuser,
    output logic                            rx_busy,
    output logic                            tx_busy,
    output logic [GW-1:0]                   tx_grant,
    output logic [STAT_WIDTH-1:0]           rx_frame_count,
    output logic [STAT_WIDTH-1:0]           rx_drop_count,
    output logic [STAT_WIDTH-1:0]           tx_frame_count
);

    localparam logic          DEF_EN = DEFAULT_CHANNEL >= 0 && DEFAULT_CHANNEL < CHANNELS;
    localparam logic [GW-1:0] DEF_CH = GW'(DEF_EN ? DEFAULT_CHANNEL : 0);

    rx_state_t     rx_state_q, rx_state_d;
    udp_rx_hdr_t   rx_hdr_q, rx_hdr_d;
    logic [GW-1:0] rx_sel_q, rx_sel_d;
    lookup_t       lk;
    tx_state_t     tx_state_q, tx_state_d;
    logic          arb_any;
    logic [CHANNELS-1:0] arb_oh;

    // RX next state: capture header, resolve channel, then forward or drop the frame
    always_comb begin
        lk = port_lookup(port_list_t'(PORT_LIST), CHANNELS, rx_hdr_q.dest_port);
        rx_state_d = rx_state_q;
        rx_hdr_d = rx_hdr_q;
        rx_sel_d = rx_sel_q;
        case (rx_state_q)
            RX_IDLE: if (rx_hdr_valid) begin
                rx_hdr_d = rx_hdr;
                rx_state_d = RX_LOOKUP;
            end
            RX_LOOKUP: begin
                rx_sel_d = lk.hit ? GW'(lk.index) : DEF_CH;
                rx_state_d = lk.hit || DEF_EN ? RX_HDR : RX_DROP;
            end
            RX_HDR: if (rx_ch_hdr_ready[rx_sel_q]) rx_state_d = RX_PAYLOAD;
            RX_PAYLOAD, RX_DROP: if (rx_tvalid && rx_tready && rx_tlast) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state, selected channel and captured header
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_hdr_q <= '0;
            rx_sel_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_hdr_q <= rx_hdr_d;
            rx_sel_q <= rx_sel_d;
        end

    // Only the selected channel ever sees a valid; data fields are broadcast
    always_comb begin
        rx_ch_hdr_valid = '0;
        rx_ch_tvalid = '0;
        rx_ch_hdr_valid[rx_sel_q] = rx_state_q == RX_HDR;
        rx_ch_tvalid[rx_sel_q] = rx_state_q == RX_PAYLOAD && rx_tvalid;
    end

    assign rx_hdr_ready = !reset && rx_state_q == RX_IDLE;
    assign rx_tready    = rx_state_q == RX_DROP || (rx_state_q == RX_PAYLOAD && rx_ch_tready[rx_sel_q]);
    assign rx_ch_hdr    = {CHANNELS{rx_hdr_q}};
    assign rx_ch_tdata  = {CHANNELS{rx_tdata}};
    assign rx_ch_tlast  = {CHANNELS{rx_tlast}};
    assign rx_ch_tuser  = {CHANNELS{rx_tuser}};
    assign rx_busy      = rx_state_q != RX_IDLE;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (tx_ch_hdr_valid),
        .update  (tx_state_q == TX_IDLE),
        .any     (arb_any),
        .gnt_oh  (arb_oh),
        .gnt_bin (tx_grant)
    );

    // TX next state: arbitrate in IDLE, then hold the grant for a whole frame
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: tx_state_d = arb_any ? TX_HDR : TX_IDLE;
            TX_HDR: if (tx_hdr_valid && tx_hdr_ready) tx_state_d = TX_PAYLOAD;
            TX_PAYLOAD: if (tx_tvalid && tx_tready && tx_tlast) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX state register
    always_ff @(posedge clk or posedge reset)
        if (reset) tx_state_q <= TX_IDLE;
        else tx_state_q <= tx_state_d;

    assign tx_hdr_valid    = tx_state_q == TX_HDR && tx_ch_hdr_valid[tx_grant];
    assign tx_hdr          = tx_ch_hdr[tx_grant];
    assign tx_ch_hdr_ready = tx_state_q == TX_HDR && tx_hdr_ready ? arb_oh : '0;
    assign tx_tvalid       = tx_state_q == TX_PAYLOAD && tx_ch_tvalid[tx_grant];
    assign tx_tdata        = tx_ch_tdata[tx_grant];
    assign tx_tlast        = tx_ch_tlast[tx_grant];
    assign tx_tuser        = tx_ch_tuser[tx_grant];
    assign tx_ch_tready    = tx_state_q == TX_PAYLOAD && tx_tready ? arb_oh : '0;
    assign tx_busy         = tx_state_q != TX_IDLE;

`ifdef UDP_PORT_ROUTER_STATS_EN
    logic [STAT_WIDTH-1:0] rx_frame_count_q, rx_frame_count_d;
    logic [STAT_WIDTH-1:0] rx_drop_count_q, rx_drop_count_d;
    logic [STAT_WIDTH-1:0] tx_frame_count_q, tx_frame_count_d;
    logic rx_end, tx_end;

    // Saturating frame counters, bumped on the tlast handshake of each frame
    always_comb begin
        rx_end = rx_tvalid && rx_tready && rx_tlast;
        tx_end = tx_tvalid && tx_tready && tx_tlast;
        rx_frame_count_d = rx_frame_count_q
                         + STAT_WIDTH'(rx_end && rx_state_q == RX_PAYLOAD && !(&rx_frame_count_q));
        rx_drop_count_d = rx_drop_count_q
                        + STAT_WIDTH'(rx_end && rx_state_q == RX_DROP && !(&rx_drop_count_q));
        tx_frame_count_d = tx_frame_count_q
                         + STAT_WIDTH'(tx_end && tx_state_q == TX_PAYLOAD && !(&tx_frame_count_q));
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rx_frame_count_q <= '0;
            rx_drop_count_q <= '0;
            tx_frame_count_q <= '0;
        end else begin
            rx_frame_count_q <= rx_frame_count_d;
            rx_drop_count_q <= rx_drop_count_d;
            tx_frame_count_q <= tx_frame_count_d;
        end

    assign rx_frame_count = rx_frame_count_q;
    assign rx_drop_count  = rx_drop_count_q;
    assign tx_frame_count = tx_frame_count_q;
`else
    assign rx_frame_count = '0;
    assign rx_drop_count  = '0;
    assign tx_frame_count = '0;
`endif

endmodule

// File: tb/tb_udp_port_router.sv
// tb_udp_port_router: directed checks of RX port routing/drop, TX round-robin, backpressure and reset
module tb_udp_port_router;
    import udp_port_router_pkg::*;

`ifdef UDP_PORT_ROUTER_STATS_EN
    localparam logic [31:0] STATS_MASK = '1;
`else
    localparam logic [31:0] STATS_MASK = '0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_hdr_valid, rx_hdr_ready, rx_tvalid, rx_tready, rx_tlast, rx_tuser;
    udp_rx_hdr_t rx_hdr;
    logic [7:0] rx_tdata;
    logic [2:0] rx_ch_hdr_valid, rx_ch_hdr_ready, rx_ch_tvalid, rx_ch_tready, rx_ch_tlast, rx_ch_tuser;
    udp_rx_hdr_t [2:0] rx_ch_hdr;
    logic [2:0][7:0] rx_ch_tdata;
    logic [2:0] tx_ch_hdr_valid, tx_ch_hdr_ready, tx_ch_tvalid, tx_ch_tready, tx_ch_tlast, tx_ch_tuser;
    udp_tx_hdr_t [2:0] tx_ch_hdr;
    logic [2:0][7:0] tx_ch_tdata;
    logic tx_hdr_valid, tx_hdr_ready, tx_tvalid, tx_tready, tx_tlast, tx_tuser;
    udp_tx_hdr_t tx_hdr;
    logic [7:0] tx_tdata;
    logic rx_busy, tx_busy;
    logic [1:0] tx_grant;
    logic [3:0] rx_frame_count, rx_drop_count, tx_frame_count;

    int checks = 0;
    int errors = 0;
    int rxf = 0, rxd = 0, txf = 0;
    int a, b;

    always #5 clk = ~clk;

    udp_port_router #(
        .CHANNELS(3), .PORT_LIST({16'd9999, 16'd5678, 16'd1234}),
        .DEFAULT_CHANNEL(-1), .STAT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_hdr_valid(rx_hdr_valid), .rx_hdr_ready(rx_hdr_ready), .rx_hdr(rx_hdr),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .rx_ch_hdr_valid(rx_ch_hdr_valid), .rx_ch_hdr_ready(rx_ch_hdr_ready), .rx_ch_hdr(rx_ch_hdr),
        .rx_ch_tdata(rx_ch_tdata), .rx_ch_tvalid(rx_ch_tvalid), .rx_ch_tready(rx_ch_tready),
        .rx_ch_tlast(rx_ch_tlast), .rx_ch_tuser(rx_ch_tuser),
        .tx_ch_hdr_valid(tx_ch_hdr_valid), .tx_ch_hdr_ready(tx_ch_hdr_ready), .tx_ch_hdr(tx_ch_hdr),
        .tx_ch_tdata(tx_ch_tdata), .tx_ch_tvalid(tx_ch_tvalid), .tx_ch_tready(tx_ch_tready),
        .tx_ch_tlast(tx_ch_tlast), .tx_ch_tuser(tx_ch_tuser),
        .tx_hdr_valid(tx_hdr_valid), .tx_hdr_ready(tx_hdr_ready), .tx_hdr(tx_hdr),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
        .rx_busy(rx_busy), .tx_busy(tx_busy), .tx_grant(tx_grant),
        .rx_frame_count(rx_frame_count), .rx_drop_count(rx_drop_count), .tx_frame_count(tx_frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int n);
        return 32'(n > 15 ? 15 : n) & STATS_MASK;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_rx_frames"}, 32'(rx_frame_count), sat(rxf));
        check({tag, "_rx_drops"}, 32'(rx_drop_count), sat(rxd));
        check({tag, "_tx_frames"}, 32'(tx_frame_count), sat(txf));
    endtask

    // Sends one RX frame of n bytes; ch<0 means it must be dropped; abort>=0 resets at that byte
    task automatic rx_frame(input logic [15:0] port, input int n, input int ch, input bit bp, input int abort);
        logic [31:0] mask;
        logic [1:0] c;
        int i, t, rcv;
        bit hs;
        mask = ch < 0 ? 32'd0 : 32'd1 << ch;
        c = ch < 0 ? 2'd0 : 2'(ch);
        rx_hdr = '{ip_source_ip: 32'h0a000001, source_port: 16'd4000, dest_port: port,
                   length: 16'(n + 8), checksum: 16'h0};
        rx_hdr_valid = 1'b1;
        #1 check("rx_hdr_ready_idle", 32'(rx_hdr_ready), 1);
        @(posedge clk); #1 rx_hdr_valid = 1'b0;
        #1 check("rx_lookup_quiet", 32'(rx_ch_hdr_valid), 0);
        check("rx_lookup_no_accept", 32'(rx_hdr_ready), 0);
        check("rx_busy", 32'(rx_busy), 1);
        @(posedge clk); #1;
        #1 check("rx_hdr_valid_sel", 32'(rx_ch_hdr_valid), mask);
        if (ch >= 0) begin
            check("rx_hdr_dest", 32'(rx_ch_hdr[c].dest_port), 32'(port));
            check("rx_hdr_src", 32'(rx_ch_hdr[c].source_port), 32'd4000);
            rx_ch_hdr_ready = 3'b111;
            @(posedge clk); #1 rx_ch_hdr_ready = 3'b000;
        end
        i = 0; t = 0; rcv = 0;
        while (i < n && t < 500) begin
            rx_tvalid = 1'b1;
            rx_tdata = 8'(i);
            rx_tlast = i == n - 1;
            rx_tuser = i[0];
            rx_ch_tready = bp && t[0] ? 3'b000 : 3'b111;
            #1;
            if (i == abort) begin
                reset = 1'b1;
                #1;
                check("rst_ch_tvalid", 32'(rx_ch_tvalid), 0);
                check("rst_ch_hdr_valid", 32'(rx_ch_hdr_valid), 0);
                check("rst_rx_tready", 32'(rx_tready), 0);
                check("rst_hdr_ready", 32'(rx_hdr_ready), 0);
                check("rst_busy", {30'd0, rx_busy, tx_busy}, 0);
                check("rst_grant", 32'(tx_grant), 2);
                rxf = 0; rxd = 0; txf = 0;
                check_counters("rst");
                rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_ch_tready = 3'b000;
                @(posedge clk); #1 reset = 1'b0;
                return;
            end
            check("rx_ch_tvalid", 32'(rx_ch_tvalid), mask);
            if (ch < 0) check("rx_drop_tready", 32'(rx_tready), 1);
            else begin
                check("rx_tready_sel", 32'(rx_tready), 32'(rx_ch_tready[c]));
                if (rx_ch_tready[c]) begin
                    check("rx_data", 32'(rx_ch_tdata[c]), 32'(rcv));
                    check("rx_last", 32'(rx_ch_tlast[c]), 32'(rcv == n - 1));
                    check("rx_user", 32'(rx_ch_tuser[c]), 32'(rcv & 1));
                    rcv++;
                end
            end
            hs = rx_tvalid && rx_tready;
            @(posedge clk); #1;
            if (hs) i++;
            t++;
        end
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_ch_tready = 3'b000;
        check("rx_no_timeout", 32'(t < 500), 1);
        if (ch >= 0) check("rx_byte_count", 32'(rcv), 32'(n));
        check("rx_busy_clear", 32'(rx_busy), 0);
    endtask

    // Channels in req each send one len-byte frame; returns the first two granted channels
    task automatic tx_run(input logic [2:0] req, input int len, input bit bp, output int first, output int second);
        logic [2:0] hdone, done, m;
        int pos[3];
        int cur, dpos, nord, t;
        first = -1; second = -1; cur = -1; dpos = 0; nord = 0; t = 0;
        hdone = '0; done = '0;
        for (int k = 0; k < 3; k++) begin
            pos[k] = 0;
            tx_ch_hdr[k] = '{ip_dest_ip: 32'h0a000002, source_port: 16'd7000,
                             dest_port: 16'(100 + k), length: 16'(len + 8), checksum: 16'h0};
        end
        while ((done & req) != req && t < 1000) begin
            for (int k = 0; k < 3; k++) begin
                tx_ch_hdr_valid[k] = req[k] & ~hdone[k];
                tx_ch_tvalid[k] = hdone[k] & ~done[k];
                tx_ch_tdata[k] = 8'(pos[k]);
                tx_ch_tlast[k] = pos[k] == len - 1;
                tx_ch_tuser[k] = pos[k][0];
            end
            tx_hdr_ready = 1'b1;
            tx_tready = !(bp && t[0]);
            #1;
            if (tx_hdr_valid && tx_hdr_ready) begin
                if (nord > 0) check("tx_prev_len", 32'(dpos), 32'(len));
                cur = int'(tx_hdr.dest_port) - 100;
                if (nord == 0) first = cur;
                else second = cur;
                nord++;
                dpos = 0;
            end
            if (tx_tvalid && tx_tready) begin
                check("tx_data", 32'(tx_tdata), 32'(dpos));
                check("tx_last", 32'(tx_tlast), 32'(dpos == len - 1));
                check("tx_user", 32'(tx_tuser), 32'(dpos & 1));
                dpos++;
            end
            if (cur >= 0) begin
                m = 3'b001 << cur;
                check("tx_excl_ready", 32'(tx_ch_tready & ~m), 0);
                check("tx_excl_hdr_ready", 32'(tx_ch_hdr_ready & ~m), 0);
            end
            for (int k = 0; k < 3; k++) begin
                if (tx_ch_hdr_valid[k] && tx_ch_hdr_ready[k]) hdone[k] = 1'b1;
                if (tx_ch_tvalid[k] && tx_ch_tready[k]) begin
                    if (pos[k] == len - 1) done[k] = 1'b1;
                    pos[k]++;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        tx_ch_hdr_valid = '0; tx_ch_tvalid = '0; tx_ch_tlast = '0; tx_tready = 1'b0;
        check("tx_no_timeout", 32'(t < 1000), 1);
        check("tx_last_len", 32'(dpos), 32'(len));
        check("tx_busy_clear", 32'(tx_busy), 0);
    endtask

    initial begin
        rx_hdr_valid = 0; rx_hdr = '0; rx_tdata = 0; rx_tvalid = 0; rx_tlast = 0; rx_tuser = 0;
        rx_ch_hdr_ready = 0; rx_ch_tready = 0;
        tx_ch_hdr_valid = 0; tx_ch_hdr = '0; tx_ch_tdata = '0; tx_ch_tvalid = 0;
        tx_ch_tlast = 0; tx_ch_tuser = 0; tx_hdr_ready = 0; tx_tready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("init_hdr_ready", 32'(rx_hdr_ready), 0);
        check("init_grant", 32'(tx_grant), 2);
        check("init_busy", {30'd0, rx_busy, tx_busy}, 0);
        check("init_valids", {26'd0, rx_ch_hdr_valid, rx_ch_tvalid}, 0);
        check_counters("init");
        reset = 1'b0;
        @(posedge clk); #1;

        rx_frame(16'd5678, 4, 1, 1'b0, -1);
        rxf++;
        check_counters("route");

        rx_frame(16'd80, 6, -1, 1'b0, -1);
        rxd++;
        check_counters("drop");

        tx_run(3'b101, 5, 1'b0, a, b);
        txf += 2;
        check("tx_order_a0", 32'(a), 0);
        check("tx_order_a1", 32'(b), 2);
        check("tx_grant_a", 32'(tx_grant), 2);

        tx_run(3'b011, 5, 1'b0, a, b);
        txf += 2;
        check("tx_order_b0", 32'(a), 0);
        check("tx_order_b1", 32'(b), 1);
        check("tx_grant_b", 32'(tx_grant), 1);

        rx_frame(16'd9999, 64, 2, 1'b1, -1);
        rxf++;
        tx_run(3'b010, 64, 1'b1, a, b);
        txf++;
        check("tx_bp_grant", 32'(a), 1);
        check("tx_bp_single", 32'(b), 32'hffffffff);
        check_counters("bp");

        rx_frame(16'd1234, 10, 0, 1'b0, 3);
        rx_frame(16'd1234, 3, 0, 1'b0, -1);
        rxf++;
        check_counters("post_rst");

        repeat (20) begin
            rx_frame(16'd80, 1, -1, 1'b0, -1);
            rxd++;
        end
        check_counters("sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
